// File: rtl/dpcm_2nd_dec.sv
// Second-order DPCM decoder: x[n] = d[n] - OFFSET + 2*x[n-1] - x[n-2] (mod 2^DATA_WIDTH),
// with valid/ready on both sides and a 2-entry show-ahead output buffer.
module dpcm_2nd_dec #(
    parameter int DATA_WIDTH = 9,
    parameter int OFFSET     = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] dpcm_data_i,
    input  logic                  dpcm_data_vld_i,
    output logic                  dpcm_data_rdy_o,
    input  logic                  hist_clr_i,
    output logic [DATA_WIDTH-1:0] raw_data_o,
    output logic                  raw_data_vld_o,
    input  logic                  raw_data_rdy_i,
    output logic [1:0]            hist_state_o,
    output logic [CNT_WIDTH-1:0]  sample_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } hist_state_t;

    localparam logic [DATA_WIDTH+1:0] OFF_EXT = (DATA_WIDTH+2)'(OFFSET);

    logic [DATA_WIDTH-1:0] h1_r, h2_r, head_r, tail_r;
    logic [1:0]            count_r;
    logic                  vld_r, rdy_r;
    hist_state_t           state_r;
    logic [CNT_WIDTH-1:0]  cnt_r;

    logic                  push_s, pop_s;
    logic [DATA_WIDTH-1:0] h1_eff_s, h2_eff_s, result_s;
    logic [DATA_WIDTH+1:0] sum_s;
    logic [DATA_WIDTH-1:0] head_n_s, tail_n_s, h1_n_s, h2_n_s;
    logic [1:0]            count_mid_s, count_n_s;
    hist_state_t           state_base_s, state_n_s;
    logic [CNT_WIDTH-1:0]  cnt_base_s, cnt_n_s;

    // Decode arithmetic, buffer update and predictor FSM next state.
    always_comb begin
        push_s = dpcm_data_vld_i & rdy_r;
        pop_s  = vld_r & raw_data_rdy_i;

        // A clear in the same cycle as an accept decodes that sample with zero history.
        if (hist_clr_i) begin
            h1_eff_s     = '0;
            h2_eff_s     = '0;
            state_base_s = ST_EMPTY;
            cnt_base_s   = '0;
        end else begin
            h1_eff_s     = h1_r;
            h2_eff_s     = h2_r;
            state_base_s = state_r;
            cnt_base_s   = cnt_r;
        end

        sum_s    = {2'b00, dpcm_data_i} - OFF_EXT + {1'b0, h1_eff_s, 1'b0} - {2'b00, h2_eff_s};
        result_s = sum_s[DATA_WIDTH-1:0];

        head_n_s    = head_r;
        tail_n_s    = tail_r;
        count_mid_s = count_r;
        if (pop_s) begin
            head_n_s    = tail_r;
            count_mid_s = count_r - 2'd1;
        end else begin
            count_mid_s = count_r;
        end

        count_n_s = count_mid_s;
        if (push_s) begin
            if (count_mid_s == 2'd0) begin
                head_n_s = result_s;
            end else begin
                tail_n_s = result_s;
            end
            count_n_s = count_mid_s + 2'd1;
        end else begin
            count_n_s = count_mid_s;
        end

        // Head register doubles as the output, so it reads zero when the buffer drains.
        if (count_n_s == 2'd0) begin
            head_n_s = '0;
        end else begin
            head_n_s = head_n_s;
        end

        h1_n_s    = h1_eff_s;
        h2_n_s    = h2_eff_s;
        cnt_n_s   = cnt_base_s;
        state_n_s = state_base_s;
        if (push_s) begin
            h2_n_s  = h1_eff_s;
            h1_n_s  = result_s;
            cnt_n_s = cnt_base_s + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            case (state_base_s)
                ST_EMPTY: state_n_s = ST_ONE;
                ST_ONE:   state_n_s = ST_FULL;
                ST_FULL:  state_n_s = ST_FULL;
                default:  state_n_s = ST_EMPTY;
            endcase
        end else begin
            state_n_s = state_base_s;
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h1_r    <= '0;
            h2_r    <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
            vld_r   <= 1'b0;
            rdy_r   <= 1'b1;
            state_r <= ST_EMPTY;
            cnt_r   <= '0;
        end else begin
            h1_r    <= h1_n_s;
            h2_r    <= h2_n_s;
            head_r  <= head_n_s;
            tail_r  <= tail_n_s;
            count_r <= count_n_s;
            vld_r   <= (count_n_s != 2'd0);
            rdy_r   <= (count_n_s < 2'd2);
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    assign dpcm_data_rdy_o = rdy_r;
    assign raw_data_o      = head_r;
    assign raw_data_vld_o  = vld_r;
    assign hist_state_o    = state_r;
    assign sample_cnt_o    = cnt_r;

endmodule
